// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: FSM state encoding, datapath widths and opcode constants.
// Imported by fetch_unit.
package riscv_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } fetch_state_t;

  localparam int          INSTR_W    = 32;
  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetcher: FETCH -> WAIT -> HOLD, 3 cycles per instr at 1-cycle memory latency.
// Holds the instruction until decode takes it (instr_valid & instr_ready); errors are sticky until reset.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        pc_out,
  input  logic               redirect,
  input  logic signed [31:0] redirect_imm,
  output logic               fetch_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_t       state, state_nxt;
  logic [INSTR_W-1:0] pc, pc_nxt;
  logic [INSTR_W-1:0] instr_q, instr_nxt;
  logic [INSTR_W-1:0] target;
  logic [CNT_W-1:0]   wait_cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      instr_q  <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      instr_q  <= instr_nxt;
      wait_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr_q;
    cnt_nxt   = wait_cnt;
    target    = pc + $unsigned(redirect_imm);
    case (state)
      FETCH: begin
        state_nxt = WAIT;
        cnt_nxt   = '0;
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_nxt = imem_rdata;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = wait_cnt + 1'b1;
          // wait_cnt counts completed empty WAIT cycles; this one is the TIMEOUT-th
          if (wait_cnt == CNT_W'(TIMEOUT - 1)) state_nxt = ERR;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          if (!redirect) begin
            pc_nxt    = pc + PC_STEP;
            state_nxt = FETCH;
          end else if (target[1:0] == 2'b00) begin
            pc_nxt    = target;
            state_nxt = FETCH;
          end else begin
            // misaligned branch target: keep the faulting pc visible on pc_out
            state_nxt = ERR;
          end
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = ERR;
    endcase
  end

  // gated with rst so no request escapes while reset is held
  assign imem_req    = (state == FETCH) && !rst;
  assign imem_addr   = pc;
  assign instr_out   = instr_q;
  assign instr_valid = (state == HOLD);
  assign pc_out      = pc;
  assign fetch_err   = (state == ERR);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: default-reset instance plus a second instance starting at 0xFFFF_FFFC.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_out;
  logic        redirect;
  logic [31:0] redirect_imm;
  logic        fetch_err;

  logic        b_rst;
  logic        b_req;
  logic [31:0] b_addr;
  logic        b_rvalid;
  logic [31:0] b_rdata;
  logic [31:0] b_instr;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] b_pc;
  logic        b_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .pc_out       (pc_out),
    .redirect     (redirect),
    .redirect_imm (redirect_imm),
    .fetch_err    (fetch_err)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(16)) dut_wrap (
    .clk          (clk),
    .rst          (b_rst),
    .imem_req     (b_req),
    .imem_addr    (b_addr),
    .imem_rvalid  (b_rvalid),
    .imem_rdata   (b_rdata),
    .instr_out    (b_instr),
    .instr_valid  (b_valid),
    .instr_ready  (b_ready),
    .pc_out       (b_pc),
    .redirect     (1'b0),
    .redirect_imm (32'h0),
    .fetch_err    (b_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From a FETCH cycle: one WAIT cycle, then rvalid with the given word -> HOLD.
  task automatic to_hold(input logic [31:0] word);
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", fetch_err); end
    total++; if (instr_out !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=00000000", instr_out); end
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=00000000", pc_out); end
    total++; if (b_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL rst_pc_wrap got=%h exp=fffffffc", b_pc); end
    rst = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%b exp=1", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL first_addr got=%h exp=00000000", imem_addr); end
  endtask

  // Three sequential fetches, instr_ready=1, 1-cycle latency: one instruction every 3 cycles.
  task automatic test_sequential();
    logic [31:0] words [3];
    words[0] = 32'h0000_0013;
    words[1] = 32'h0010_0093;
    words[2] = 32'h0020_0113;
    for (int i = 0; i < 3; i++) begin
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin bad++; $display("FAIL seq_req%0d got=%b/%h exp=1/%h", i, imem_req, imem_addr, 32'(4 * i)); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL seq_fetch_valid%0d got=%b exp=0", i, instr_valid); end
      step();
      total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL seq_wait%0d got req=%b valid=%b exp 0/0", i, imem_req, instr_valid); end
      imem_rvalid = 1'b1;
      imem_rdata  = words[i];
      step();
      imem_rvalid = 1'b0;
      total++; if (instr_valid !== 1'b1 || instr_out !== words[i]) begin bad++; $display("FAIL seq_hold%0d got=%b/%h exp=1/%h", i, instr_valid, instr_out, words[i]); end
      total++; if (pc_out !== 32'(4 * i)) begin bad++; $display("FAIL seq_pc%0d got=%h exp=%h", i, pc_out, 32'(4 * i)); end
      step();
    end
  endtask

  // pc=0x0C: sequential to 0x10, then taken branch with offset -8 -> 0x08.
  task automatic test_redirect_back();
    to_hold(32'hAAAA_0001);
    step();
    total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL to_0x10 got=%h exp=00000010", imem_addr); end
    to_hold(32'hFE00_0CE3);
    redirect     = 1'b1;
    redirect_imm = -32'sd8;
    step();
    redirect     = 1'b0;
    redirect_imm = 32'h0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("FAIL redirect_neg got=%b/%h exp=1/00000008", imem_req, imem_addr); end
  endtask

  // pc=0x08: decode stalls 5 cycles with redirect asserted; stray rvalid in HOLD must not land.
  task automatic test_stall();
    to_hold(32'h1234_5678);
    instr_ready  = 1'b0;
    redirect     = 1'b1;
    redirect_imm = 32'h40;
    imem_rvalid  = 1'b1;
    imem_rdata   = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (instr_valid !== 1'b1 || instr_out !== 32'h1234_5678 || pc_out !== 32'h8) begin bad++; $display("FAIL stall%0d got=%b/%h/%h exp=1/12345678/00000008", i, instr_valid, instr_out, pc_out); end
    end
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    instr_ready = 1'b1;
    step();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin bad++; $display("FAIL stall_resume got=%b/%h exp=1/0000000c", imem_req, imem_addr); end
  endtask

  task automatic test_wrap_sequential();
    b_rst = 1'b0;
    #1;
    total++; if (b_req !== 1'b1 || b_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_first got=%b/%h exp=1/fffffffc", b_req, b_addr); end
    step();
    b_rvalid = 1'b1;
    b_rdata  = 32'hCAFE_0001;
    step();
    b_rvalid = 1'b0;
    total++; if (b_valid !== 1'b1 || b_instr !== 32'hCAFE_0001) begin bad++; $display("FAIL wrap_hold got=%b/%h exp=1/cafe0001", b_valid, b_instr); end
    step();
    total++; if (b_req !== 1'b1 || b_addr !== 32'h0) begin bad++; $display("FAIL wrap_second got=%b/%h exp=1/00000000", b_req, b_addr); end
    b_rst = 1'b1;
  endtask

  // From reset pc=0: branch by -4 wraps to 0xFFFF_FFFC.
  task automatic test_neg_wrap();
    pulse_reset();
    to_hold(32'hFE00_0EE3);
    redirect     = 1'b1;
    redirect_imm = -32'sd4;
    step();
    redirect     = 1'b0;
    redirect_imm = 32'h0;
    total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL neg_wrap got=%h exp=fffffffc", imem_addr); end
  endtask

  task automatic test_timeout();
    pulse_reset();
    step();
    for (int i = 0; i < 15; i++) step();
    total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b exp=0", fetch_err); end
    step();
    total++; if (fetch_err !== 1'b1 || instr_valid !== 1'b0) begin bad++; $display("FAIL timeout_err got=%b/%b exp=1/0", fetch_err, instr_valid); end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (imem_req !== 1'b0 || fetch_err !== 1'b1 || instr_valid !== 1'b0) begin bad++; $display("FAIL err_sticky%0d got req=%b err=%b valid=%b exp 0/1/0", i, imem_req, fetch_err, instr_valid); end
    end
    imem_rvalid = 1'b0;
    pulse_reset();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_err !== 1'b0) begin bad++; $display("FAIL timeout_recover got=%b/%h/%b exp=1/00000000/0", imem_req, imem_addr, fetch_err); end
  endtask

  // Jump to 0x20, then a branch offset of 6 gives a misaligned target.
  task automatic test_misaligned();
    to_hold(32'h0200_006F);
    redirect     = 1'b1;
    redirect_imm = 32'h20;
    step();
    redirect = 1'b0;
    total++; if (imem_addr !== 32'h20) begin bad++; $display("FAIL jump_0x20 got=%h exp=00000020", imem_addr); end
    to_hold(32'h0000_0363);
    redirect     = 1'b1;
    redirect_imm = 32'h6;
    step();
    redirect     = 1'b0;
    redirect_imm = 32'h0;
    total++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL misalign_err got err=%b req=%b valid=%b exp 1/0/0", fetch_err, imem_req, instr_valid); end
    total++; if (pc_out !== 32'h20) begin bad++; $display("FAIL misalign_pc got=%h exp=00000020", pc_out); end
    pulse_reset();
  endtask

  task automatic test_reset_mid_flight();
    to_hold(32'h0000_0093);
    step();
    to_hold(32'h0040_0113);
    instr_ready = 1'b0;
    total++; if (pc_out !== 32'h4) begin bad++; $display("FAIL pre_rst_pc got=%h exp=00000004", pc_out); end
    rst = 1'b1;
    #1;
    total++; if (instr_valid !== 1'b0 || instr_out !== 32'h0 || pc_out !== 32'h0) begin bad++; $display("FAIL async_rst_hold got=%b/%h/%h exp=0/00000000/00000000", instr_valid, instr_out, pc_out); end
    step();
    rst = 1'b0;
    instr_ready = 1'b1;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL rst_hold_refetch got=%b/%h exp=1/00000000", imem_req, imem_addr); end
    step();
    step();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin bad++; $display("FAIL rst_wait_refetch got=%b/%h/%b exp=1/00000000/0", imem_req, imem_addr, instr_valid); end
  endtask

  initial begin
    rst          = 1'b1;
    b_rst        = 1'b1;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;
    instr_ready  = 1'b1;
    redirect     = 1'b0;
    redirect_imm = 32'h0;
    b_rvalid     = 1'b0;
    b_rdata      = 32'h0;
    b_ready      = 1'b1;
    step();
    step();
    test_reset();
    test_sequential();
    test_redirect_back();
    test_stall();
    test_wrap_sequential();
    test_neg_wrap();
    test_timeout();
    test_misaligned();
    test_reset_mid_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum number of cycles spent in WAIT before an error is flagged.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  one-cycle fetch request to instruction memory.
REQ-006 imem_addr  output  32  fetch address; valid while imem_req=1.
REQ-007 imem_rvalid  input  1  instruction memory read data valid.
REQ-008 imem_rdata  input  32  instruction word; sampled only when imem_rvalid=1 in WAIT.
REQ-009 instr_out  output  32  held instruction word presented to decode and the sign extender.
REQ-010 instr_valid  output  1  instr_out and pc_out are valid.
REQ-011 instr_ready  input  1  decode consumes the instruction; handshake = instr_valid & instr_ready.
REQ-012 pc_out  output  32  PC of instr_out.
REQ-013 redirect  input  1  branch taken for the presented instruction; meaningful only on a handshake cycle.
REQ-014 redirect_imm  input  32 signed  sign-extended B-type offset, LSB already 0.
REQ-015 fetch_err  output  1  sticky error: misaligned target or memory timeout.

Function
REQ-016 SHALL implement FSM states FETCH, WAIT, HOLD and ERR.
REQ-017 FETCH: imem_req=1 and imem_addr=pc for exactly one cycle; next state WAIT.
REQ-018 WAIT: imem_req=0; on imem_rvalid=1, capture imem_rdata into instr_out and go to HOLD; otherwise increment the wait counter.
REQ-019 WAIT: when the wait counter reaches TIMEOUT with no imem_rvalid, go to ERR.
REQ-020 HOLD: instr_valid=1; instr_out and pc_out stay stable until the handshake.
REQ-021 HOLD handshake with redirect=0: pc <= pc+4; next state FETCH.
REQ-022 HOLD handshake with redirect=1: target = pc + redirect_imm.
  - target[1:0]=0: pc <= target; next state FETCH.
  - target[1:0]!=0: go to ERR; pc unchanged.
REQ-023 redirect without a handshake SHALL be ignored.
REQ-024 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 = 0, and negative offsets wrap.
REQ-025 imem_rvalid outside WAIT SHALL be ignored; the minimum memory latency is 1 cycle (request cycle, then at earliest rvalid in the next cycle).
REQ-026 ERR: fetch_err=1, instr_valid=0, imem_req=0; ERR is exited only by reset.
REQ-027 Back-to-back throughput SHALL be 1 instruction per 3 cycles with 1-cycle memory latency and instr_ready held at 1.
REQ-028 The wait counter SHALL clear on every entry to WAIT.

Reset
REQ-029 On rst=1, asynchronously: state=FETCH, pc=RESET_PC, instr_out=0, instr_valid=0, imem_req=0, fetch_err=0, wait counter=0.
REQ-030 rst asserted mid-WAIT or mid-HOLD SHALL discard the in-flight instruction; after release, the first request goes to RESET_PC.
REQ-031 imem_req SHALL assert in the first clk cycle after rst deasserts.

Structure
REQ-032 The FSM state enum, the constants INSTR_W=32 and PC_STEP=4, and opcode OPC_BRANCH=7'b1100011 SHALL reside in the shared package riscv_pkg.
REQ-033 No sub-module is required; the adder and next-PC mux SHALL be inline.

Verification
REQ-034 Reset, memory latency 1, instr_ready=1 -> addresses 0x0, 0x4, 0x8 are requested; instr_valid pulses every 3 cycles; pc_out matches each address.
REQ-035 Handshake at pc=0x10 with redirect=1 and redirect_imm=-8 -> next imem_addr=0x08.
REQ-036 RESET_PC=32'hFFFF_FFFC, sequential fetch -> second imem_addr=0x0000_0000.
REQ-037 instr_ready=0 for 5 cycles in HOLD with redirect=1 -> instr_out and pc_out stable, redirect ignored; the handshake then resumes normal fetch.
REQ-038 No imem_rvalid for 16 cycles in WAIT -> fetch_err=1, imem_req stays 0 until rst.
REQ-039 Handshake at pc=0x20 with redirect_imm=0x6 -> fetch_err=1; rst pulse mid-HOLD -> next imem_addr=RESET_PC.
